// File: rtl/matmul_addr_pkg.sv
// Shared widths, types and the row-major address helper for the
// matmul address generator. No ports; imported by the RTL files.
package matmul_addr_pkg;

    localparam int DIM_W_DEF  = 8;
    localparam int ADDR_W_DEF = 16;

    typedef logic [DIM_W_DEF-1:0]  dim_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // row*stride + col at the default widths, wrapping modulo 2^ADDR_W
    function automatic addr_t row_major_addr(
        input dim_t row,
        input dim_t stride,
        input dim_t col
    );
        logic [2*DIM_W_DEF-1:0] prod;
        prod = {{DIM_W_DEF{1'b0}}, row} * {{DIM_W_DEF{1'b0}}, stride};
        return addr_t'(prod) + addr_t'(col);
    endfunction

endpackage

// File: rtl/matmul_address_module_addr_calc.sv
// Combinational row-major address: addr = row*stride + col.
// Ports: row, stride, col (DIM_W) in; addr (ADDR_W) out, truncated.
module addr_calc
    import matmul_addr_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [DIM_W-1:0]  row,
    input  logic [DIM_W-1:0]  stride,
    input  logic [DIM_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [2*DIM_W-1:0] prod;
    logic [ADDR_W-1:0]  prod_ext;
    logic [ADDR_W-1:0]  col_ext;

    // full-width product, then zero-extend both terms before summing
    assign prod     = {{DIM_W{1'b0}}, row} * {{DIM_W{1'b0}}, stride};
    assign prod_ext = ADDR_W'(prod);
    assign col_ext  = ADDR_W'(col);
    assign addr     = prod_ext + col_ext;

endmodule

// File: rtl/matmul_address_module.sv
// Registered A/B/D address generator for D[i][k] += A[i][j]*B[j][k].
// Ports: clk, rst (sync, active-high), IN_VALID, CI/CJ/CK dims,
// SI/SJ/SK indices in; OUT_VALID, AA, AB, AD out; RANGE_ERR out
// only when ADDR_RANGE_CHECK_EN is defined. Latency is one cycle.
module matmul_address_module
    import matmul_addr_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IN_VALID,
    input  logic [DIM_W-1:0]  CI,
    input  logic [DIM_W-1:0]  CJ,
    input  logic [DIM_W-1:0]  CK,
    input  logic [DIM_W-1:0]  SI,
    input  logic [DIM_W-1:0]  SJ,
    input  logic [DIM_W-1:0]  SK,
    output logic              OUT_VALID,
    output logic [ADDR_W-1:0] AA,
    output logic [ADDR_W-1:0] AB,
`ifdef ADDR_RANGE_CHECK_EN
    output logic [ADDR_W-1:0] AD,
    output logic              RANGE_ERR
`else
    output logic [ADDR_W-1:0] AD
`endif
);

    logic [ADDR_W-1:0] aa_next;
    logic [ADDR_W-1:0] ab_next;
    logic [ADDR_W-1:0] ad_next;

    addr_calc #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_calc_a (
        .row    (SI),
        .stride (CJ),
        .col    (SJ),
        .addr   (aa_next)
    );

    addr_calc #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_calc_b (
        .row    (SJ),
        .stride (CK),
        .col    (SK),
        .addr   (ab_next)
    );

    addr_calc #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_calc_d (
        .row    (SI),
        .stride (CK),
        .col    (SK),
        .addr   (ad_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
        end
    end

    // addresses hold their last value while IN_VALID is low
    always_ff @(posedge clk) begin
        if (rst) begin
            AA <= '0;
            AB <= '0;
            AD <= '0;
        end else if (IN_VALID) begin
            AA <= aa_next;
            AB <= ab_next;
            AD <= ad_next;
        end
    end

`ifdef ADDR_RANGE_CHECK_EN
    logic range_bad;

    assign range_bad = (SI >= CI) || (SJ >= CJ) || (SK >= CK);

    always_ff @(posedge clk) begin
        if (rst) begin
            RANGE_ERR <= 1'b0;
        end else if (IN_VALID) begin
            RANGE_ERR <= range_bad;
        end
    end
`else
    // CI only feeds the range check, which is absent in this build
    logic ci_unused;
    assign ci_unused = ^CI;
`endif

endmodule

// File: tb/tb_matmul_address_module.sv
// Self-checking bench for matmul_address_module: scoreboard queue
// filled at drive time, popped when OUT_VALID is observed.
module tb_matmul_address_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  ci, cj, ck, si, sj, sk;
    logic        out_valid;
    logic [15:0] aa, ab, ad;
    logic        range_err;

    typedef struct {
        logic [15:0] aa;
        logic [15:0] ab;
        logic [15:0] ad;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    matmul_address_module dut (
        .clk       (clk),
        .rst       (rst),
        .IN_VALID  (in_valid),
        .CI        (ci),
        .CJ        (cj),
        .CK        (ck),
        .SI        (si),
        .SJ        (sj),
        .SK        (sk),
        .OUT_VALID (out_valid),
        .AA        (aa),
        .AB        (ab),
`ifdef ADDR_RANGE_CHECK_EN
        .AD        (ad),
        .RANGE_ERR (range_err)
`else
        .AD        (ad)
`endif
    );

`ifndef ADDR_RANGE_CHECK_EN
    assign range_err = 1'b0;
`endif

    // drive one cycle of inputs; record expected result if valid
    task automatic drive(input bit v, input int c_i, input int c_j,
                         input int c_k, input int s_i, input int s_j,
                         input int s_k);
        exp_t e;
        in_valid = v;
        ci = 8'(c_i); cj = 8'(c_j); ck = 8'(c_k);
        si = 8'(s_i); sj = 8'(s_j); sk = 8'(s_k);
        if (v) begin
            e.aa  = 16'((s_i * c_j + s_j) % 65536);
            e.ab  = 16'((s_j * c_k + s_k) % 65536);
            e.ad  = 16'((s_i * c_k + s_k) % 65536);
            e.err = (s_i >= c_i) || (s_j >= c_j) || (s_k >= c_k);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(1, 3, 4, 5, 2, 3, 4);
            @(posedge clk); #1;
            sb.delete();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid got=%b want=0", out_valid);
            end
            n_checks++;
            if ({aa, ab, ad} !== 48'h0) begin
                n_fail++;
                $display("FAIL reset_addr got=%0d/%0d/%0d want=0/0/0",
                         aa, ab, ad);
            end
            n_checks++;
            if (range_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_err got=%b want=0", range_err);
            end
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        exp_t e;
        drive(1, 3, 4, 5, 2, 3, 4);
        @(posedge clk); #1;
        drive(0, 3, 4, 5, 0, 0, 0);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_valid got=%b want=1", out_valid);
        end
        n_checks++;
        if ({aa, ab, ad} !== {16'd11, 16'd19, 16'd14} ||
            {aa, ab, ad} !== {e.aa, e.ab, e.ad}) begin
            n_fail++;
            $display("FAIL nominal_addr got=%0d/%0d/%0d want=11/19/14",
                     aa, ab, ad);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_drop got=%b want=0", out_valid);
        end
        n_checks++;
        if ({aa, ab, ad} !== {16'd11, 16'd19, 16'd14}) begin
            n_fail++;
            $display("FAIL nominal_hold got=%0d/%0d/%0d want=11/19/14",
                     aa, ab, ad);
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int   pulses = 0;
        int   bad = 0;
        logic [14:0] ad_seen = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 5; k++) begin
                    drive(1, 3, 4, 5, i, j, k);
                    @(posedge clk); #1;
                    if (out_valid === 1'b1 && sb.size() > 0) begin
                        pulses++;
                        e = sb.pop_front();
                        if ({aa, ab, ad} !== {e.aa, e.ab, e.ad}) bad++;
                        if (ad < 15) ad_seen[ad[3:0]] = 1'b1;
                    end
                end
        drive(0, 3, 4, 5, 0, 0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL sweep_addr got=%0d bad want=0", bad);
        end
        n_checks++;
        if (pulses !== 60) begin
            n_fail++;
            $display("FAIL sweep_pulses got=%0d want=60", pulses);
        end
        n_checks++;
        if (ad_seen !== 15'h7fff) begin
            n_fail++;
            $display("FAIL sweep_ad_cover got=%h want=7fff", ad_seen);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_end_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_max();
        exp_t e;
        drive(1, 255, 255, 255, 254, 254, 254);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_checks++;
        if ({aa, ab, ad} !== {3{16'd65024}} ||
            {aa, ab, ad} !== {e.aa, e.ab, e.ad}) begin
            n_fail++;
            $display("FAIL max_addr got=%0d/%0d/%0d want=65024 x3",
                     aa, ab, ad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_range();
        exp_t e;
        drive(1, 3, 4, 5, 3, 0, 0);
        @(posedge clk); #1;
        drive(1, 3, 4, 5, 2, 0, 0);
        e = sb.pop_front();
        n_checks++;
        if ({aa, ab, ad} !== {16'd12, 16'd0, 16'd15}) begin
            n_fail++;
            $display("FAIL range_addr got=%0d/%0d/%0d want=12/0/15",
                     aa, ab, ad);
        end
`ifdef ADDR_RANGE_CHECK_EN
        n_checks++;
        if (range_err !== 1'b1 || e.err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_err_set got=%b want=1", range_err);
        end
`endif
        @(posedge clk); #1;
        drive(0, 3, 4, 5, 9, 9, 9);
        e = sb.pop_front();
        n_checks++;
        if ({aa, ab, ad} !== {16'd8, 16'd0, 16'd10}) begin
            n_fail++;
            $display("FAIL range_ok_addr got=%0d/%0d/%0d want=8/0/10",
                     aa, ab, ad);
        end
`ifdef ADDR_RANGE_CHECK_EN
        n_checks++;
        if (range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL range_err_clr got=%b want=0", range_err);
        end
        drive(1, 3, 4, 5, 0, 4, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        @(posedge clk); #1;
        n_checks++;
        if (range_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_err_hold got=%b want=1", range_err);
        end
`else
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_midreset();
        exp_t e;
        drive(1, 3, 4, 5, 1, 2, 3);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || {aa, ab, ad} !== {e.aa, e.ab, e.ad}) begin
            n_fail++;
            $display("FAIL midrst_pre got=%b %0d/%0d/%0d want=1 %0d/%0d/%0d",
                     out_valid, aa, ab, ad, e.aa, e.ab, e.ad);
        end
        rst = 1'b1;
        drive(1, 3, 4, 5, 2, 1, 1);
        @(posedge clk); #1;
        sb.delete();
        n_checks++;
        if (out_valid !== 1'b0 || {aa, ab, ad} !== 48'h0) begin
            n_fail++;
            $display("FAIL midrst_clear got=%b %0d/%0d/%0d want=0 0/0/0",
                     out_valid, aa, ab, ad);
        end
        rst = 1'b0;
        drive(1, 3, 4, 5, 2, 2, 2);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || {aa, ab, ad} !== {16'd10, 16'd12, 16'd12}) begin
            n_fail++;
            $display("FAIL midrst_resume got=%b %0d/%0d/%0d want=1 10/12/12",
                     out_valid, aa, ab, ad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   bad = 0;
        int   seen = 0;
        int   sent = 0;
        bit   v;
        for (int n = 0; n < 40; n++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) sent++;
            drive(v, $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                seen++;
                if (sb.size() == 0) bad++;
                else begin
                    e = sb.pop_front();
                    last = e;
                    if ({aa, ab, ad} !== {e.aa, e.ab, e.ad}) bad++;
`ifdef ADDR_RANGE_CHECK_EN
                    if (range_err !== e.err) bad++;
`endif
                end
            end else if (seen > 0 && {aa, ab, ad} !== {last.aa, last.ab, last.ad}) begin
                bad++;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        if (out_valid === 1'b1 && sb.size() > 0) begin
            seen++;
            e = sb.pop_front();
            if ({aa, ab, ad} !== {e.aa, e.ab, e.ad}) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_data got=%0d bad want=0", bad);
        end
        n_checks++;
        if (seen !== sent || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d left=%0d want=%0d left=0",
                     seen, sb.size(), sent);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_nominal();
        test_sweep();
        test_max();
        test_range();
        test_midreset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_address_module.md
Name: matmul_address_module

Overview:
Registered address generator for the matrix-multiply datapath, computing D[i][k] += A[i][j]*B[j][k].
- Inputs: matrix dimensions (CI rows of A/D, CJ shared inner dimension, CK columns of B/D) and the current loop indices (SI, SJ, SK).
- Outputs: row-major linear memory addresses for the A, B and D operands.
- Sits between the loop-control FSM and the three operand/result RAMs.

Parameters:
DIM_W, 8, width of dimension and index inputs
ADDR_W, 16, width of address outputs (must be >= 2*DIM_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
IN_VALID  input  1  qualifies CI..SK this cycle
CI  input  DIM_W  row count of A and D
CJ  input  DIM_W  column count of A / row count of B
CK  input  DIM_W  column count of B and D
SI  input  DIM_W  current row index i
SJ  input  DIM_W  current inner index j
SK  input  DIM_W  current column index k
OUT_VALID  output  1  AA/AB/AD updated this cycle
AA  output  ADDR_W  address of A[i][j]
AB  output  ADDR_W  address of B[j][k]
AD  output  ADDR_W  address of D[i][k]
RANGE_ERR  output  1  index out of range (only with ADDR_RANGE_CHECK_EN)

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset: AA, AB, AD = 0; OUT_VALID = 0; RANGE_ERR = 0. Reset wins over IN_VALID in the same cycle. Reset mid-stream discards the in-flight result.
- Address formulas, evaluated at the clock edge where IN_VALID=1:
  - AA = SI*CJ + SJ
  - AB = SJ*CK + SK
  - AD = SI*CK + SK
- Arithmetic: unsigned. Each product is 2*DIM_W bits wide, zero-extended to ADDR_W, summed, and truncated modulo 2^ADDR_W.
- Overflow: with default widths no overflow is possible for in-range indices (max 254*255+254 = 65024).
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, and OUT_VALID=1 for that one cycle.
- Throughput: one new address set per cycle; back-to-back IN_VALID is supported, no stall or backpressure.
- IN_VALID=0: OUT_VALID=0 next cycle; AA/AB/AD hold their last values (not cleared).
- Zero dimensions (e.g. CJ=0): formulas are still applied, e.g. AA=SJ. No special-casing.
- CI is used only by range checking; the address formulas do not depend on it.
- No combinational path from inputs to outputs.

Optional Feature:
Macro: ADDR_RANGE_CHECK_EN
- Defined:
  - RANGE_ERR port exists and is registered alongside the addresses.
  - RANGE_ERR=1 with OUT_VALID when SI>=CI, SJ>=CJ or SK>=CK; otherwise 0.
  - Addresses are still computed and output unchanged.
  - RANGE_ERR holds when IN_VALID=0.
- Undefined: RANGE_ERR port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package matmul_addr_pkg holds:
  - default DIM_W/ADDR_W constants
  - typedefs dim_t (DIM_W bits) and addr_t (ADDR_W bits)
  - a row-major address function prototype
- One sub-module, addr_calc: combinational (row*stride + col) with truncation to ADDR_W.
  - Instantiated three times: (SI,CJ,SJ), (SJ,CK,SK), (SI,CK,SK).
  - The top level holds only the registers, valid pipe and range check.

Test Plan:
- Reset: assert rst 2 cycles with IN_VALID=1 and nonzero inputs -> AA=AB=AD=0, OUT_VALID=0, RANGE_ERR=0.
- Nominal: CI=3, CJ=4, CK=5, SI=2, SJ=3, SK=4 pulsed 1 cycle -> next cycle AA=11, AB=19, AD=14, OUT_VALID=1; the following cycle OUT_VALID=0 with values held.
- Full sweep: CI=3, CJ=4, CK=5, nested loops SI<3, SJ<4, SK<5 with IN_VALID continuous -> each output equals the formulas 1 cycle later, 60 consecutive OUT_VALID pulses, AD covers 0..14.
- Max widths: CI=CJ=CK=255, SI=SJ=SK=254 -> AA=AB=AD=65024, no wrap.
- Range check (macro defined): CI=3, CJ=4, CK=5, SI=3, SJ=0, SK=0 -> RANGE_ERR=1, AA=12; then SI=2 -> RANGE_ERR=0.
- Mid-stream reset: rst asserted the cycle after a valid input -> OUT_VALID=0 and addresses 0 on the next cycle; normal operation resumes 1 cycle after rst deasserts.
